// File: rtl/timer_pkg.sv
// Shared constants and FSM state type for the timer display BCD path.
// Digit width, add-3 correction threshold/amount, converter states.
package timer_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: +3 when the digit is >= 5, else pass-through.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adjust
  import timer_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] dig_in,
  output logic [BCD_DIGIT_W-1:0] dig_out
);

  // Inputs 5..9 land on 8..12, so the 4-bit add never wraps for legal digits.
  always_comb begin
    dig_out = dig_in;
    if (dig_in >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      dig_out = dig_in + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter, one bit per clock; done BIN_W clocks after start is accepted.
// No backpressure: start is ignored while busy; SEQ_BIN_TO_BCD_SAT_EN adds ovf and saturates to all 9s.
module seq_bin_to_bcd
  import timer_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BIN_W-1:0]                bin_in,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out
`ifdef SEQ_BIN_TO_BCD_SAT_EN
  ,
  output logic                            ovf
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_adj, sr_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              last;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .dig_in  (sr_q  [BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
        .dig_out (sr_adj[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
    end
  endgenerate

  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  assign sr_shift          = sr_adj << 1;
  assign last              = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef SEQ_BIN_TO_BCD_SAT_EN
  // Any 1 leaving the top digit means the running value passed 10^DIGITS-1;
  // the value only grows as bits are appended, so the flag is made sticky.
  logic ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, ovf_now;
  assign ovf_now = ovf_acc_q | sr_adj[SR_W-1];
  assign ovf     = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
          ovf_acc_d = 1'b0;
`endif
        end
      end
      CONVERT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_BIN_TO_BCD_SAT_EN
        ovf_acc_d = ovf_now;
`endif
        if (last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
          ovf_d = ovf_now;
          bcd_d = ovf_now ? {DIGITS{4'h9}} : sr_shift[SR_W-1 -: BCD_W];
`else
          bcd_d = sr_shift[SR_W-1 -: BCD_W];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Bench for seq_bin_to_bcd: a 3-digit and a 2-digit instance run in lock-step,
// expected BCD values are queued at start acceptance and compared at done.
module tb_seq_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy, done, busy2, done2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
  logic        ovf3, ovf2;
`endif

  typedef struct {
    logic [11:0] b3;
    logic [7:0]  b2;
    logic        ovf2;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd3)
`ifdef SEQ_BIN_TO_BCD_SAT_EN
    , .ovf(ovf3)
`endif
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2)
`ifdef SEQ_BIN_TO_BCD_SAT_EN
    , .ovf(ovf2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s check", tag);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic push(input int v);
    exp_t        e;
    logic [31:0] t3, t2;
    t3 = to_bcd(v, 3);
    t2 = to_bcd(v, 2);
    e.b3   = t3[11:0];
    e.b2   = t2[7:0];
    e.ovf2 = 1'b0;
`ifdef SEQ_BIN_TO_BCD_SAT_EN
    if (v > 99) begin
      e.b2   = 8'h99;
      e.ovf2 = 1'b1;
    end
`endif
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Drives one conversion; returns in the done cycle so a following call
  // exercises start-during-done acceptance.
  task automatic run_conv(input int v, input bit hold);
    int n;
    bin_in = 8'(v);
    start  = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    push(v);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    wait_done(n);
    check("latency", n, 32'd8);
  endtask

  // Scoreboard / protocol monitor.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done_prev) check("done_one_cycle", {31'b0, done}, 32'd0);
    if (done === 1'b1) begin
      check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("bcd3", {20'b0, bcd3}, {20'b0, e.b3});
        check("bcd2", {24'b0, bcd2}, {24'b0, e.b2});
        check("done2", {31'b0, done2}, 32'd1);
`ifdef SEQ_BIN_TO_BCD_SAT_EN
        check("ovf3", {31'b0, ovf3}, 32'd0);
        check("ovf2", {31'b0, ovf2}, {31'b0, e.ovf2});
`endif
      end
    end
    done_prev = done;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_bcd3", {20'b0, bcd3}, 32'd0);
    check("rst_bcd2", {24'b0, bcd2}, 32'd0);
    #10 rst = 1'b0;
    tick();

    run_conv(0, 1'b0);
    run_conv(99, 1'b0);
    run_conv(255, 1'b0);
    run_conv(150, 1'b0);
    run_conv(98, 1'b0);
    tick();
    tick();

    for (int i = 0; i < 256; i++) run_conv(i, 1'b0);
    tick();

    // Start while busy is ignored; bin_in changes mid-conversion have no effect.
    bin_in = 8'd42;
    start  = 1'b1;
    tick();
    start = 1'b0;
    push(42);
    tick();
    tick();
    bin_in = 8'd77;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = 8'd99;
    wait_done(n);
    check("latency_busy_start", n, 32'd5);
    run_conv(77, 1'b0);

    // Held start restarts each BIN_W+1 clocks.
    run_conv(33, 1'b1);
    run_conv(34, 1'b1);
    start = 1'b0;
    tick();

    // Abort mid-conversion with an asynchronous reset.
    bin_in = 8'd200;
    start  = 1'b1;
    tick();
    start = 1'b0;
    push(200);
    tick();
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_bcd3", {20'b0, bcd3}, 32'd0);
    check("abort_bcd2", {24'b0, bcd2}, 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    run_conv(13, 1'b0);

    tick();
    tick();
    tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
